// File: rtl/ysyx_23060236_mdu_pkg.sv
// Shared op encodings (funct3) and FSM state encodings for the multiply/divide unit.
package ysyx_23060236_mdu_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_mul_op(input logic [2:0] f);
        return ~f[2];
    endfunction

endpackage

// File: rtl/ysyx_23060236_mdu_div.sv
// Restoring divider datapath: operand magnitudes, one restoring step per cycle,
// sign fix-up of the stepped values, and the divide-by-zero / overflow fast paths.
module ysyx_23060236_mdu_div #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            step,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            fast,
    output logic [XLEN-1:0] fast_quo,
    output logic [XLEN-1:0] fast_rem,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);
    logic [XLEN-1:0] r_q, q_q, d_q;
    logic            neg_q, neg_r;
    logic            a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0] a_mag, b_mag, r_next, q_next;
    logic [XLEN:0]   shifted, diff;

    always_comb begin
        a_neg    = is_signed & dividend[XLEN-1];
        b_neg    = is_signed & divisor[XLEN-1];
        a_mag    = a_neg ? -dividend : dividend;
        b_mag    = b_neg ? -divisor : divisor;
        div_zero = (divisor == '0);
        ovf      = is_signed & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (divisor == '1);
        fast     = div_zero | ovf;
        fast_quo = div_zero ? '1 : dividend;
        fast_rem = div_zero ? dividend : '0;
    end

    // One restoring step; the outputs show the sign-fixed values after this step,
    // so on the final iteration they are the finished quotient and remainder.
    always_comb begin
        shifted = {r_q, q_q[XLEN-1]};
        diff    = shifted - {1'b0, d_q};
        r_next  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        q_next  = {q_q[XLEN-2:0], ~diff[XLEN]};
        quo     = neg_q ? -q_next : q_next;
        rem     = neg_r ? -r_next : r_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (start) begin
            r_q   <= '0;
            q_q   <= a_mag;
            d_q   <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end else if (step) begin
            r_q <= r_next;
            q_q <= q_next;
        end
    end

endmodule

// File: rtl/ysyx_23060236_mdu.sv
// RISC-V M-extension multiply/divide unit: iterative shift-add multiplier with
// MUL_UNROLL bits per cycle, restoring divider, single outstanding operation.
module ysyx_23060236_mdu
    import ysyx_23060236_mdu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;

    if ((XLEN % MUL_UNROLL) != 0 || (MUL_UNROLL & (MUL_UNROLL - 1)) != 0) begin : g_bad_param
        $error("MUL_UNROLL must be a power of two dividing XLEN");
    end

    state_t            state, state_next;
    logic [2:0]        op;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, acc_next, mcand;
    logic [XLEN-1:0]   mplier;
    logic              mplier_signed, mcand_signed_in;
    logic              accept, mul_last, div_last;
    logic              div_fast;
    logic [XLEN-1:0]   div_fast_quo, div_fast_rem, div_quo, div_rem;

    // Handshakes: a request transfers when in_valid & in_ready & ~flush; a result
    // transfers when out_valid & out_ready. flush overrides both.
    assign accept          = (state == S_IDLE) & in_valid & ~flush;
    assign mul_last        = (cnt == CW'(XLEN / MUL_UNROLL - 1));
    assign div_last        = (cnt == CW'(XLEN - 1));
    assign mcand_signed_in = (funct3 != OP_MULHU);

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) begin
                if (is_mul_op(funct3)) state_next = S_MUL;
                else if (div_fast)     state_next = S_DONE;
                else                   state_next = S_DIV;
            end
            S_MUL:  if (flush) state_next = S_IDLE; else if (mul_last) state_next = S_DONE;
            S_DIV:  if (flush) state_next = S_IDLE; else if (div_last) state_next = S_DONE;
            S_DONE: if (flush | out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // A signed multiplier's top bit carries negative weight, so it is subtracted.
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < MUL_UNROLL; i++) begin
            if (mplier[i]) begin
                if (mul_last && i == MUL_UNROLL - 1 && mplier_signed)
                    acc_next = acc_next - (mcand << i);
                else
                    acc_next = acc_next + (mcand << i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op            <= '0;
            cnt           <= '0;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            mplier_signed <= 1'b0;
            result        <= '0;
        end else if (accept) begin
            op            <= funct3;
            cnt           <= '0;
            acc           <= '0;
            mcand         <= {{XLEN{src1[XLEN-1] & mcand_signed_in}}, src1};
            mplier        <= src2;
            mplier_signed <= (funct3 == OP_MUL) | (funct3 == OP_MULH);
            if (!is_mul_op(funct3) && div_fast)
                result <= funct3[1] ? div_fast_rem : div_fast_quo;
        end else if (flush) begin
            cnt <= '0;
        end else if (state == S_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << MUL_UNROLL;
            mplier <= mplier >> MUL_UNROLL;
            cnt    <= cnt + CW'(1);
            if (mul_last)
                result <= (op == OP_MUL) ? acc_next[XLEN-1:0] : acc_next[2*XLEN-1:XLEN];
        end else if (state == S_DIV) begin
            cnt <= cnt + CW'(1);
            if (div_last)
                result <= op[1] ? div_rem : div_quo;
        end
    end

    ysyx_23060236_mdu_div #(.XLEN(XLEN)) u_div (
        .clock     (clock),
        .reset     (reset),
        .start     (accept & ~is_mul_op(funct3)),
        .step      (state == S_DIV),
        .is_signed (~funct3[0]),
        .dividend  (src1),
        .divisor   (src2),
        .fast      (div_fast),
        .fast_quo  (div_fast_quo),
        .fast_rem  (div_fast_rem),
        .quo       (div_quo),
        .rem       (div_rem)
    );

endmodule

// File: tb/tb_ysyx_23060236_mdu.sv
// Bench for ysyx_23060236_mdu: directed vector table, random ops against a
// plain-arithmetic model, and handwritten stall / flush / reset sequences.
module tb_ysyx_23060236_mdu;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = '0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    always #5 clock = ~clock;

    ysyx_23060236_mdu #(.XLEN(32), .MUL_UNROLL(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return 9;
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Offer a request and hold it until accepted; then scramble the inputs.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int waited = 0;
        @(negedge clock);
        in_valid = 1'b1; funct3 = f; src1 = a; src2 = b;
        while (!in_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        funct3 = 3'($urandom);
        src1 = $urandom;
        src2 = $urandom;
    endtask

    // Leaves the bench at the negedge where out_valid was first seen.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!out_valid && lat < 200);
        if (!out_valid) check("done_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_check(input string name, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        start_op(f, a, b);
        wait_done(lat);
        check({name, "_result"}, result, exp_res);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        consume();
    endtask

    initial begin
        int lat;
        logic [2:0]  rf;
        logic [31:0] ra, rb, held;

        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 9};
        vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 9};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 9};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 9};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'b101, 32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{3'b111, 32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'b110, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1};

        // Clock / reset
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'd0);

        // flush wins over in_valid in IDLE
        in_valid = 1'b1; funct3 = 3'b000; src1 = 32'd3; src2 = 32'd3; flush = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clock);
        check("flush_prio_in_ready", 32'(in_ready), 32'd1);

        foreach (vecs[i])
            run_check($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

        for (int i = 0; i < 24; i++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_check($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, ref_res(rf, ra, rb), ref_lat(rf, ra, rb));
        end

        // Hold the result in DONE with out_ready low
        start_op(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_done(lat);
        check("stall_latency", 32'(lat), 32'd9);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("stall_result", result, 32'hFFFF_FFEB);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        consume();
        @(negedge clock);
        check("after_consume_in_ready", 32'(in_ready), 32'd1);
        check("after_consume_out_valid", 32'(out_valid), 32'd0);
        held = 32'hFFFF_FFEB;

        // Flush 10 cycles into a DIV
        start_op(3'b101, 32'd1000, 32'd3);
        repeat (10) @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_result_kept", result, held);
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (out_valid) lat++;
        end
        check("flush_no_out_valid", 32'(lat), 32'd0);

        // Reset 3 cycles into a MUL
        start_op(3'b001, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_result", result, 32'd0);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (out_valid) lat++;
        end
        check("midreset_no_out_valid", 32'(lat), 32'd0);
        run_check("post_reset_mulhu", 3'b011, 32'd3, 32'd5, 32'd0, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
